// File: rtl/hdlc_pkg.sv
// Shared types and defaults for the HDLC receive path.
package hdlc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVING,
    READY
  } rx_buf_state_t;

  localparam logic [7:0] FLAG          = 8'h7E;
  localparam int         BUF_DEPTH_DEF = 128;
  localparam int         FCS_BYTES_DEF = 2;

endpackage

// File: rtl/hdlc_rx_buf_mem.sv
// Byte-wide frame memory: one synchronous write port and one registered read port.
// The read register holds its value between reads and clears on reset.
module hdlc_rx_buf_mem #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hdlc_rx_frame_buffer.sv
// Single-frame receive buffer behind the HDLC Rx channel: captures de-stuffed bytes,
// strips the FCS from the reported size, flags abort/error/overflow/lost frames.
module hdlc_rx_frame_buffer
  import hdlc_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int FCS_BYTES = FCS_BYTES_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_WrBuff,
  input  logic              Rx_ValidFrame,
  input  logic              Rx_EoF,
  input  logic              Rx_AbortSignal,
  input  logic              Rx_FCSerr,
  input  logic              Rx_RdBuff,
  input  logic              Rx_Drop,
  output logic [7:0]        Rx_DataOut,
  output logic              Rx_Ready,
  output logic [ADDR_W:0]   Rx_FrameSize,
  output logic              Rx_Overflow,
  output logic              Rx_FrameError,
  output logic              Rx_AbortFlag,
  output logic              Rx_FrameLost
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0] FCS_C   = (ADDR_W+1)'(FCS_BYTES);

  rx_buf_state_t     state, state_nxt;
  logic [ADDR_W-1:0] wptr, rptr, wr_addr;
  logic [ADDR_W:0]   cnt, size, cnt_inc;
  logic              ovf, ovf_inc, valid_d;
  logic              wr_en, rd_en, wr_space, runt, last_rd, start;

  // Byte count saturates at the buffer depth; excess bytes only raise overflow.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v, input logic en);
    return (en && v < DEPTH_C) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    wr_space  = cnt < DEPTH_C;
    cnt_inc   = sat_inc(cnt, Rx_WrBuff);
    ovf_inc   = ovf | (Rx_WrBuff & ~wr_space);
    runt      = (cnt_inc <= FCS_C) & ~ovf_inc;
    last_rd   = ({1'b0, rptr} == size - 1'b1);
    start     = Rx_WrBuff & Rx_ValidFrame;
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = wptr;
    rd_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RECEIVING;
          wr_en     = 1'b1;
          wr_addr   = '0;
        end
      end
      RECEIVING: begin
        wr_en = Rx_WrBuff & wr_space;
        if (Rx_AbortSignal)  state_nxt = IDLE;
        else if (Rx_EoF)     state_nxt = (Rx_FCSerr || runt) ? IDLE : READY;
      end
      READY: begin
        if (Rx_Drop) begin
          state_nxt = IDLE;
        end else if (Rx_RdBuff) begin
          rd_en = 1'b1;
          if (last_rd) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      wptr          <= '0;
      rptr          <= '0;
      cnt           <= '0;
      size          <= '0;
      ovf           <= 1'b0;
      valid_d       <= 1'b0;
      Rx_FrameError <= 1'b0;
      Rx_AbortFlag  <= 1'b0;
      Rx_FrameLost  <= 1'b0;
    end else begin
      state         <= state_nxt;
      valid_d       <= Rx_ValidFrame;
      Rx_FrameError <= 1'b0;
      Rx_AbortFlag  <= 1'b0;
      Rx_FrameLost  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            wptr <= ADDR_W'(1);
            cnt  <= (ADDR_W+1)'(1);
            ovf  <= 1'b0;
          end
        end
        RECEIVING: begin
          if (wr_en) wptr <= wptr + 1'b1;
          cnt <= cnt_inc;
          ovf <= ovf_inc;
          if (Rx_AbortSignal) begin
            Rx_AbortFlag <= 1'b1;
            ovf          <= 1'b0;
            wptr         <= '0;
            cnt          <= '0;
          end else if (Rx_EoF) begin
            wptr <= '0;
            cnt  <= '0;
            if (Rx_FCSerr || runt) Rx_FrameError <= 1'b1;
            else                   size <= ovf_inc ? DEPTH_C : cnt_inc - FCS_C;
          end
        end
        READY: begin
          // Only the first cycle of a new frame reports it as lost.
          Rx_FrameLost <= Rx_ValidFrame & ~valid_d;
          if (Rx_Drop) begin
            size <= '0;
            ovf  <= 1'b0;
            rptr <= '0;
          end else if (Rx_RdBuff) begin
            if (last_rd) begin
              rptr <= '0;
              size <= '0;
            end else begin
              rptr <= rptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Rx_Ready     = (state == READY);
  assign Rx_FrameSize = size;
  assign Rx_Overflow  = ovf;

  hdlc_rx_buf_mem #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (Clk),
    .rst     (Rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (Rx_Data),
    .rd_en   (rd_en),
    .rd_addr (rptr),
    .rd_data (Rx_DataOut)
  );

endmodule

// File: doc/hdlc_rx_frame_buffer.md
Name: hdlc_rx_frame_buffer

Overview:
Receive-side frame buffer directly downstream of the HDLC Rx channel. It captures de-stuffed bytes written by the Rx channel during a valid frame and strips the 2-byte FCS from the reported length. It flags abort, FCS error, overflow and lost frames, and presents a completed frame to the register interface for byte-wise readout. It holds one frame at a time.

Parameters:
BUF_DEPTH, 128, byte capacity of frame memory (power of two)
ADDR_W, 7, log2(BUF_DEPTH)
FCS_BYTES, 2, trailing FCS bytes excluded from reported frame size

Ports:
Clk  in  1  system clock, all logic on posedge
Rst  in  1  synchronous, active-high reset
Rx_Data  in  8  byte from Rx channel
Rx_WrBuff  in  1  write strobe, one cycle per byte
Rx_ValidFrame  in  1  high while Rx channel is inside a frame
Rx_EoF  in  1  end-of-frame pulse (closing flag seen)
Rx_AbortSignal  in  1  abort pulse from Rx channel
Rx_FCSerr  in  1  FCS check result, sampled only with Rx_EoF
Rx_RdBuff  in  1  read strobe from register interface
Rx_Drop  in  1  software discard of the held frame
Rx_DataOut  out  8  read data
Rx_Ready  out  1  complete frame available
Rx_FrameSize  out  ADDR_W+1  payload byte count of held frame
Rx_Overflow  out  1  held frame exceeded BUF_DEPTH
Rx_FrameError  out  1  one-cycle pulse: frame rejected (FCS error or runt)
Rx_AbortFlag  out  1  one-cycle pulse: frame aborted
Rx_FrameLost  out  1  one-cycle pulse: frame arrived while buffer held a frame

Behaviour:
- Reset: state IDLE, wptr=rptr=cnt=0, all outputs 0. Memory contents not reset.
- FSM states: IDLE, RECEIVING, READY.
- IDLE -> RECEIVING on the first Rx_WrBuff with Rx_ValidFrame=1. That byte is written at address 0. cnt=1, Rx_Overflow cleared.
- RECEIVING, Rx_WrBuff: if cnt<BUF_DEPTH, write at wptr, wptr++, cnt++. Otherwise discard the byte and set Rx_Overflow. Rx_Overflow is sticky until the next frame start, Rst, or Rx_Drop.
- RECEIVING, Rx_AbortSignal: -> IDLE. Rx_AbortFlag pulses next cycle. Contents discarded; Overflow cleared.
- RECEIVING, Rx_EoF, three cases:
  - Rx_FCSerr=1, or cnt<=FCS_BYTES with no overflow: -> IDLE, Rx_FrameError pulse.
  - Overflow set: -> READY, Rx_FrameSize=BUF_DEPTH, Rx_Overflow=1.
  - Otherwise: -> READY, Rx_FrameSize=cnt-FCS_BYTES.
  - Rx_Ready rises the cycle after Rx_EoF.
- Simultaneous events in RECEIVING:
  - Rx_WrBuff and Rx_EoF together: the byte is counted before the size is computed.
  - Rx_AbortSignal and Rx_EoF together: abort wins.
- READY, read path:
  - Each Rx_RdBuff registers mem[rptr] onto Rx_DataOut, visible 1 cycle later, then rptr++.
  - The read that consumes byte Rx_FrameSize-1 returns to IDLE. Rx_Ready, Rx_FrameSize and rptr clear on the same edge that updates Rx_DataOut.
  - Rx_DataOut holds its last value until the next read.
- READY, Rx_Drop: -> IDLE immediately. Clears Ready, Size, Overflow. If Rx_Drop and Rx_RdBuff are asserted together, Drop wins and Rx_DataOut is unchanged.
- READY, rising edge of Rx_ValidFrame: bytes are ignored and Rx_FrameLost pulses once for that frame. The held frame is unaffected.
- Rx_RdBuff outside READY is ignored. Rx_WrBuff in IDLE with Rx_ValidFrame=0 is ignored.
- Width rule: cnt and Rx_FrameSize are ADDR_W+1 bits. No wrap is possible because cnt saturates at BUF_DEPTH.
- Reset asserted mid-frame or mid-read returns to the reset state on the next edge.

Decomposition:
- Package hdlc_pkg holds:
  - enum rx_buf_state_t {IDLE, RECEIVING, READY}
  - localparam FLAG=8'h7E
  - default BUF_DEPTH and FCS_BYTES
- One sub-module, hdlc_rx_buf_mem: single-port-write/single-port-read synchronous RAM, BUF_DEPTH x 8, registered read. The FSM, counters and flags stay in the top.

Test Plan:
1. Frame 0x11,0x22,0x33 + 2 FCS bytes, then Rx_EoF with FCSerr=0 -> Rx_Ready=1 next cycle, Rx_FrameSize=3. Three reads give 0x11,0x22,0x33. Ready=0 after the third read.
2. Same frame with Rx_FCSerr=1 at Rx_EoF -> Rx_FrameError pulse of exactly 1 cycle, Rx_Ready stays 0, a subsequent Rx_RdBuff leaves Rx_DataOut unchanged.
3. 130 Rx_WrBuff bytes 0..129 then Rx_EoF -> Rx_Overflow=1, Rx_FrameSize=128, last read returns 127.
4. 4 bytes then Rx_AbortSignal in the same cycle as Rx_EoF -> Rx_AbortFlag pulse, Rx_Ready=0, state IDLE.
5. Frame held (Ready=1); second frame of 5 bytes arrives -> Rx_FrameLost single pulse; first frame reads back intact. Then Rx_Drop with Rx_RdBuff together -> Ready=0, DataOut unchanged.
6. Rst asserted after 2 bytes of a frame -> all outputs 0 next cycle. A following 3-byte+FCS frame is received with Rx_FrameSize=3.
